// File: rtl/gpio_in_conditioner_if.sv
// rtl/gpio_in_conditioner_if.sv - configuration, pad and status bundle for gpio_in_conditioner
interface gpio_in_conditioner_if #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 16
);
  logic [WIDTH-1:0]      PAD_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic [WIDTH-1:0]      DB_EN;
  logic [WIDTH-1:0]      RISE_EN;
  logic [WIDTH-1:0]      FALL_EN;
  logic [WIDTH-1:0]      IRQ_MASK;
  logic [WIDTH-1:0]      IRQ_CLR;
  logic [WIDTH-1:0]      GPIOIN;
  logic [WIDTH-1:0]      IRQ_PEND;
  logic                  IRQ;

  modport master (
    output PAD_IN, PRESCALE, DB_EN, RISE_EN, FALL_EN, IRQ_MASK, IRQ_CLR,
    input  GPIOIN, IRQ_PEND, IRQ
  );

  modport slave (
    input  PAD_IN, PRESCALE, DB_EN, RISE_EN, FALL_EN, IRQ_MASK, IRQ_CLR,
    output GPIOIN, IRQ_PEND, IRQ
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - per-pin sync, debounce, edge detect and sticky IRQ pending
module gpio_in_conditioner #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 16,
  parameter int DB_COUNT   = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  gpio_in_conditioner_if.slave  bus
);
  localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            gpio_q, gpio_d;
  logic [WIDTH-1:0]            prev_q, prev_d;
  logic [WIDTH-1:0]            pend_q, pend_d;
  logic [PRESCALE_W-1:0]       pcnt_q, pcnt_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        tick;
  logic [WIDTH-1:0]            rise, fall;

  always_comb begin
    s1_d   = bus.PAD_IN;
    s2_d   = s1_q;
    prev_d = gpio_q;
    gpio_d = gpio_q;
    cnt_d  = cnt_q;

    // Equality compare: a PRESCALE drop below pcnt lets pcnt wrap round to it.
    tick   = (pcnt_q == bus.PRESCALE);
    pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);

    for (int i = 0; i < WIDTH; i++) begin
      if (!bus.DB_EN[i]) begin
        gpio_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (s2_q[i] == gpio_q[i]) begin
        cnt_d[i]  = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          gpio_d[i] = s2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    rise   = gpio_q & ~prev_q;
    fall   = ~gpio_q & prev_q;
    // Set terms OR'd in after the clear so a coincident edge keeps the flag.
    pend_d = (pend_q & ~bus.IRQ_CLR) | (rise & bus.RISE_EN) | (fall & bus.FALL_EN);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s1_q   <= '0;
      s2_q   <= '0;
      gpio_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      gpio_q <= gpio_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.GPIOIN   = gpio_q;
  assign bus.IRQ_PEND = pend_q;
  assign bus.IRQ      = |(pend_q & bus.IRQ_MASK);
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - directed self-checking bench for gpio_in_conditioner
module tb_gpio_in_conditioner;
  logic HCLK;
  logic HRESET;
  int   checks;
  int   passes;

  gpio_in_conditioner_if #(.WIDTH(16), .PRESCALE_W(16)) bus ();

  gpio_in_conditioner #(.WIDTH(16), .PRESCALE_W(16), .DB_COUNT(4)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    HRESET       = 1'b1;
    bus.PAD_IN   = 16'hFFFF;
    bus.PRESCALE = 16'd3;
    bus.DB_EN    = '0;
    bus.RISE_EN  = '0;
    bus.FALL_EN  = '0;
    bus.IRQ_MASK = '0;
    bus.IRQ_CLR  = '0;
    step(3);
    chk("reset_gpioin", 32'(bus.GPIOIN), 32'h0);
    chk("reset_irq", 32'(bus.IRQ), 32'h0);
    chk("reset_pend", 32'(bus.IRQ_PEND), 32'h0);

    // Passthrough latency after reset release
    HRESET = 1'b0;
    step(2);
    chk("pass_2cyc", 32'(bus.GPIOIN), 32'h0);
    step(1);
    chk("pass_3cyc", 32'(bus.GPIOIN), 32'hFFFF);
    step(1);
    chk("pass_no_pend", 32'(bus.IRQ_PEND), 32'h0);

    // Bring every pin low, then enable debounce on pin 0
    bus.PAD_IN = 16'h0000;
    step(4);
    chk("pass_low", 32'(bus.GPIOIN), 32'h0);
    bus.DB_EN = 16'h0001;
    step(1);

    // Debounce accept: s2 changes at edge 2, four ticks land within edges 2..17
    bus.PAD_IN = 16'h0001;
    step(13);
    chk("db_before_4th_tick", 32'(bus.GPIOIN[0]), 32'h0);
    step(4);
    chk("db_accept", 32'(bus.GPIOIN[0]), 32'h1);

    // Drop back to 0 without debounce, re-arm
    bus.DB_EN  = 16'h0000;
    bus.PAD_IN = 16'h0000;
    step(4);
    chk("db_reset_low", 32'(bus.GPIOIN[0]), 32'h0);
    bus.DB_EN = 16'h0001;

    // Debounce reject: 10-cycle pulse sees at most 3 ticks
    bus.PAD_IN = 16'h0001;
    step(10);
    bus.PAD_IN = 16'h0000;
    step(20);
    chk("db_reject", 32'(bus.GPIOIN[0]), 32'h0);

    // Counter restarted from 0: a fresh high needs the full 4 ticks again
    bus.PAD_IN = 16'h0001;
    step(13);
    chk("db_restart_hold", 32'(bus.GPIOIN[0]), 32'h0);
    step(4);
    chk("db_restart_accept", 32'(bus.GPIOIN[0]), 32'h1);
    bus.DB_EN = 16'h0000;

    // Rising edge on pin 3 sets a sticky flag; fall is ignored
    bus.RISE_EN  = 16'h0008;
    bus.IRQ_MASK = 16'h0008;
    bus.PAD_IN   = 16'h0009;
    step(3);
    chk("edge_gpioin3", 32'(bus.GPIOIN), 32'h0009);
    chk("edge_pend_not_yet", 32'(bus.IRQ_PEND), 32'h0);
    step(1);
    chk("edge_pend3", 32'(bus.IRQ_PEND), 32'h0008);
    chk("edge_irq", 32'(bus.IRQ), 32'h1);
    step(1);
    bus.PAD_IN = 16'h0001;
    step(6);
    chk("fall_no_change", 32'(bus.IRQ_PEND), 32'h0008);
    bus.IRQ_CLR = 16'h0008;
    step(1);
    bus.IRQ_CLR = 16'h0000;
    chk("clr_pend3", 32'(bus.IRQ_PEND), 32'h0);
    chk("clr_irq", 32'(bus.IRQ), 32'h0);

    // Set and clear in the same cycle on pin 5
    bus.RISE_EN  = 16'h0020;
    bus.IRQ_MASK = 16'h0000;
    bus.PAD_IN   = 16'h0021;
    step(3);
    chk("coll_gpioin5", 32'(bus.GPIOIN[5]), 32'h1);
    bus.IRQ_CLR = 16'h0020;
    step(1);
    bus.IRQ_CLR = 16'h0000;
    chk("coll_set_wins", 32'(bus.IRQ_PEND), 32'h0020);
    bus.IRQ_CLR = 16'h0020;
    step(1);
    bus.IRQ_CLR = 16'h0000;
    chk("coll_clear_later", 32'(bus.IRQ_PEND), 32'h0);

    // Masked pending on pin 7, then unmask without a clock edge
    bus.RISE_EN = 16'h0080;
    bus.PAD_IN  = 16'h00A1;
    step(4);
    chk("mask_pend7", 32'(bus.IRQ_PEND), 32'h0080);
    chk("mask_irq_low", 32'(bus.IRQ), 32'h0);
    bus.IRQ_MASK = 16'h0080;
    #1;
    chk("unmask_irq", 32'(bus.IRQ), 32'h1);

    // Asynchronous reset between edges
    #2;
    HRESET = 1'b1;
    #1;
    chk("async_pend", 32'(bus.IRQ_PEND), 32'h0);
    chk("async_irq", 32'(bus.IRQ), 32'h0);
    chk("async_gpioin", 32'(bus.GPIOIN), 32'h0);
    step(2);
    HRESET = 1'b0;
    step(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Input-conditioning stage directly upstream of the AHB GPIO peripheral; drives its GPIOIN bus.
- Per pin: synchronises the raw pad input, applies optional debounce and detects edges.
- Latches interrupt-pending flags and raises a single maskable IRQ line.
- Configuration arrives as static register outputs from the GPIO register file.

Parameters:
- WIDTH, 16: number of GPIO pins.
- PRESCALE_W, 16: width of debounce prescaler reload value.
- DB_COUNT, 4: consecutive prescaler ticks a changed level must persist before it is accepted (>=1).

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  asynchronous, active-high reset.
- PAD_IN  in  WIDTH  raw asynchronous pad inputs.
- PRESCALE  in  PRESCALE_W  debounce tick period minus 1.
- DB_EN  in  WIDTH  per-pin debounce enable.
- RISE_EN  in  WIDTH  per-pin rising-edge interrupt enable.
- FALL_EN  in  WIDTH  per-pin falling-edge interrupt enable.
- IRQ_MASK  in  WIDTH  per-pin IRQ output mask (1 = contributes).
- IRQ_CLR  in  WIDTH  per-pin one-cycle clear pulse for pending flags.
- GPIOIN  out  WIDTH  conditioned level to the GPIO peripheral.
- IRQ_PEND  out  WIDTH  pending flags, readable by software.
- IRQ  out  1  OR of (IRQ_PEND & IRQ_MASK).

Behaviour:
- Reset (HRESET=1, asynchronous): sync stages, filtered level, previous level, prescaler, debounce counters and IRQ_PEND all go to 0. Consequently GPIOIN=0, IRQ_PEND=0 and IRQ=0 immediately. No edge is generated on reset release.
- Reset mid-operation: any in-progress debounce count is discarded. The pending flag is lost.
- Synchroniser: s1<=PAD_IN and s2<=s1 each cycle. Two-cycle latency.
- Prescaler:
  - Free-running counter pcnt; tick=1 when pcnt==PRESCALE, and pcnt then reloads to 0. Otherwise pcnt increments.
  - PRESCALE=0 gives a tick every cycle.
  - A PRESCALE change takes effect on the next compare; if pcnt>PRESCALE, pcnt counts up through wrap-around to reach the new value.
- Filter, DB_EN[i]=0:
  - GPIOIN[i]<=s2[i] every cycle, so pad-to-GPIOIN latency is 3 cycles.
  - Counter cnt[i] is held at 0.
- Filter, DB_EN[i]=1:
  - If s2[i]==GPIOIN[i]: cnt[i]<=0.
  - Else, on tick: if cnt[i]==DB_COUNT-1, then GPIOIN[i]<=s2[i] and cnt[i]<=0; otherwise cnt[i]++.
  - Else, without tick: cnt[i] is held.
  - Any glitch returning to the old level before acceptance restarts the count from 0.
  - cnt width is clog2(DB_COUNT), minimum 1.
- DB_EN changing mid-count: clearing DB_EN zeroes cnt[i] at once. Setting it starts counting from 0.
- Edge detect:
  - prev<=GPIOIN every cycle.
  - rise=GPIOIN&~prev; fall=~GPIOIN&prev. Each is a one-cycle pulse in the cycle after GPIOIN changes.
- Pending:
  - IRQ_PEND[i] is set on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
  - It is cleared by IRQ_CLR[i].
  - Set and clear in the same cycle: set wins and the flag stays 1.
  - Flags are sticky; further edges while pending have no extra effect.
- IRQ: combinational OR over IRQ_PEND&IRQ_MASK. Masking does not clear pending; unmasking an already-pending pin raises IRQ immediately.
- Pins are fully independent. Any mix of simultaneous edges on multiple pins sets all matching flags in one cycle.

Test Plan:
- Reset/passthrough:
  - Hold HRESET, drive PAD_IN=16'hFFFF → GPIOIN=0, IRQ=0.
  - Release reset with DB_EN=0 → GPIOIN=16'hFFFF exactly 3 cycles after release. No IRQ_PEND set (RISE_EN=0).
- Debounce accept:
  - DB_EN[0]=1, PRESCALE=3, DB_COUNT=4; PAD_IN[0] 0→1 and held.
  - GPIOIN[0] rises on the 4th tick after s2 changes (within 2+16 cycles). Not before the 4th tick.
- Debounce reject: same setup, PAD_IN[0] high for 10 cycles then low → GPIOIN[0] stays 0, cnt returns to 0.
- Edge/IRQ:
  - RISE_EN[3]=1, FALL_EN[3]=0, IRQ_MASK[3]=1, DB_EN=0; pulse PAD_IN[3] high for 5 cycles.
  - IRQ_PEND[3]=1 and IRQ=1 after rise; no change on fall.
  - IRQ_CLR[3] pulse → IRQ_PEND[3]=0, IRQ=0.
- Set-vs-clear collision: assert IRQ_CLR[5] in the exact cycle rise[5] fires with RISE_EN[5]=1 → IRQ_PEND[5]=1 after the edge.
- Mask and async reset:
  - IRQ_PEND[7]=1 with IRQ_MASK[7]=0 → IRQ=0. Set IRQ_MASK[7]=1 → IRQ=1 the same cycle.
  - Then assert HRESET between clock edges → IRQ_PEND=0 and IRQ=0 without waiting for a clock edge.
